// File: rtl/conv_grp_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv_grp_sched
// Purpose  : Output-channel-group scheduler for the layer-1 convolution
//            engine. Each group is sequenced through weight load, conv run,
//            pipeline drain and writeback. The scheduler drives the input
//            controller's ConvValid handshake and exposes the per-group
//            weight RAM base address to the DMA weight loader.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock
//   rstn         in   synchronous active-low reset
//   Start_i      in   start pulse, sampled in IDLE only
//   NumGrp_i     in   number of groups, latched on accepted start
//   Abort_i      in   abort, highest priority
//   WtLdReq_o    out  weight load request (level)
//   WtLdDone_i   in   weight load complete (pulse)
//   WtBase_o     out  weight RAM base of the current group
//   ConvValid_o  out  ConvValid to the input controller
//   ConvBusy_i   in   busy flag from the input controller
//   WbReq_o      out  writeback request (level)
//   WbDone_i     in   writeback complete (pulse)
//   GrpIdx_o     out  current group index
//   Busy_o       out  high in every state but IDLE
//   Done_o       out  one-cycle completion pulse
//   Err_o        out  sticky conv-start timeout flag
// ============================================================================
module conv_grp_sched #(
    parameter int         GRP_W     = 4,
    parameter logic [8:0] WT_STRIDE = 9'd16,
    parameter int         DRAIN_CYC = 4,
    parameter int         TIMEOUT   = 63
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             Start_i,
    input  logic [GRP_W-1:0] NumGrp_i,
    input  logic             Abort_i,
    output logic             WtLdReq_o,
    input  logic             WtLdDone_i,
    output logic [8:0]       WtBase_o,
    output logic             ConvValid_o,
    input  logic             ConvBusy_i,
    output logic             WbReq_o,
    input  logic             WbDone_i,
    output logic [GRP_W-1:0] GrpIdx_o,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Err_o
);

    // One shared counter serves both the CSTART timeout and the DRAIN flush,
    // so it is sized for the larger of the two limits.
    localparam int c_CNT_MAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_DRN_LAST = c_CNT_W'(DRAIN_CYC - 1);
    localparam logic [GRP_W-1:0]   c_GRP_ONE  = GRP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WLD    = 3'd1,
        S_CSTART = 3'd2,
        S_CRUN   = 3'd3,
        S_DRAIN  = 3'd4,
        S_WB     = 3'd5,
        S_REL    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [GRP_W-1:0]   r_grp_q,   w_grp_d;
    logic [GRP_W-1:0]   r_num_q,   w_num_d;
    logic               r_err_q,   w_err_d;

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_grp_q   <= '0;
            r_num_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_grp_q   <= w_grp_d;
            r_num_q   <= w_num_d;
            r_err_q   <= w_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. The counter defaults to zero so it always restarts
    // at 0 on entry to CSTART or DRAIN; it only advances while dwelling.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = '0;
        w_grp_d   = r_grp_q;
        w_num_d   = r_num_q;
        w_err_d   = r_err_q;

        case (r_state_q)
            S_IDLE: begin
                if (Start_i) begin
                    w_num_d   = NumGrp_i;
                    w_grp_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = (NumGrp_i == '0) ? S_DONE : S_WLD;
                end
            end
            S_WLD: begin
                if (WtLdDone_i) begin
                    w_state_d = S_CSTART;
                end
            end
            S_CSTART: begin
                // Busy already high on the first CSTART cycle is accepted.
                if (ConvBusy_i) begin
                    w_state_d = S_CRUN;
                end else if (r_cnt_q == c_TMO_LAST) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            S_CRUN: begin
                if (!ConvBusy_i) begin
                    w_state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cnt_q == c_DRN_LAST) begin
                    w_state_d = S_WB;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            S_WB: begin
                if (WbDone_i) begin
                    w_state_d = S_REL;
                end
            end
            S_REL: begin
                // Index stops at the last group, so it never wraps.
                if (r_grp_q == (r_num_q - c_GRP_ONE)) begin
                    w_state_d = S_DONE;
                end else begin
                    w_grp_d   = r_grp_q + c_GRP_ONE;
                    w_state_d = S_WLD;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything: return to IDLE, keep index and error.
        if (Abort_i) begin
            w_state_d = S_IDLE;
            w_cnt_d   = '0;
            w_grp_d   = r_grp_q;
            w_num_d   = r_num_q;
            w_err_d   = r_err_q;
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------------
    assign WtLdReq_o   = (r_state_q == S_WLD);
    assign ConvValid_o = (r_state_q == S_CSTART) || (r_state_q == S_CRUN) ||
                         (r_state_q == S_DRAIN)  || (r_state_q == S_WB);
    assign WbReq_o     = (r_state_q == S_WB);
    assign Busy_o      = (r_state_q != S_IDLE);
    assign Done_o      = (r_state_q == S_DONE);
    assign Err_o       = r_err_q;
    assign GrpIdx_o    = r_grp_q;

    // 9-bit product wraps naturally, giving the base modulo 512.
    assign WtBase_o    = 9'(r_grp_q) * WT_STRIDE;

endmodule
`default_nettype wire

// File: tb/tb_conv_grp_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv_grp_sched
// Purpose  : Self-checking bench for conv_grp_sched. Each job is described
//            as a timeline of phases (weight load, conv start, run, drain,
//            writeback, release, done) with randomized handshake delays and
//            ignored-input noise; the expected outputs of every cycle follow
//            from the phase the job is in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_grp_sched;

    localparam int         GRP_W     = 4;
    localparam logic [8:0] WT_STRIDE = 9'd16;
    localparam int         DRAIN_CYC = 4;
    localparam int         TIMEOUT   = 63;

    localparam int K_IDLE = 0, K_WLD = 1, K_CS = 2, K_CR = 3;
    localparam int K_DR = 4, K_WB = 5, K_REL = 6, K_DONE = 7;

    typedef struct packed {
        logic       wtld;
        logic       cv;
        logic       wb;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] grp;
        logic [8:0] base;
    } out_t;

    typedef struct packed {
        logic       start;
        logic [3:0] num;
        logic       abort;
        logic       rstn;
        logic       wtld_done;
        logic       busy;
        logic       wb_done;
    } in_t;

    typedef struct packed {
        out_t o;
        in_t  i;
    } ent_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic             Start_i;
    logic [GRP_W-1:0] NumGrp_i;
    logic             Abort_i;
    logic             WtLdReq_o;
    logic             WtLdDone_i;
    logic [8:0]       WtBase_o;
    logic             ConvValid_o;
    logic             ConvBusy_i;
    logic             WbReq_o;
    logic             WbDone_i;
    logic [GRP_W-1:0] GrpIdx_o;
    logic             Busy_o;
    logic             Done_o;
    logic             Err_o;

    ent_t tl[$];
    int   n_chk   = 0;
    int   n_err   = 0;
    int   cur_grp = 0;
    bit   cur_err = 1'b0;
    int   job     = 0;
    int   fwd = -1, fbd = -1, fbl = -1, fwbd = -1;

    always #5 clk = ~clk;

    conv_grp_sched #(
        .GRP_W     (GRP_W),
        .WT_STRIDE (WT_STRIDE),
        .DRAIN_CYC (DRAIN_CYC),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .Start_i     (Start_i),
        .NumGrp_i    (NumGrp_i),
        .Abort_i     (Abort_i),
        .WtLdReq_o   (WtLdReq_o),
        .WtLdDone_i  (WtLdDone_i),
        .WtBase_o    (WtBase_o),
        .ConvValid_o (ConvValid_o),
        .ConvBusy_i  (ConvBusy_i),
        .WbReq_o     (WbReq_o),
        .WbDone_i    (WbDone_i),
        .GrpIdx_o    (GrpIdx_o),
        .Busy_o      (Busy_o),
        .Done_o      (Done_o),
        .Err_o       (Err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs while the job sits in phase k.
    function automatic out_t mk_out(int k, int grp, bit err);
        out_t o;
        o.wtld = (k == K_WLD);
        o.cv   = (k == K_CS) || (k == K_CR) || (k == K_DR) || (k == K_WB);
        o.wb   = (k == K_WB);
        o.busy = (k != K_IDLE);
        o.done = (k == K_DONE);
        o.err  = err;
        o.grp  = 4'(grp);
        o.base = 9'((grp * int'(WT_STRIDE)) % 512);
        return o;
    endfunction

    function automatic in_t quiet_in();
        in_t i;
        i = '0;
        i.rstn = 1'b1;
        return i;
    endfunction

    // Random activity on inputs that phase k must ignore.
    function automatic in_t noisy_in(int k);
        in_t i;
        i = quiet_in();
        if (k != K_IDLE) begin
            i.start = ($urandom_range(3, 0) == 0);
            i.num   = 4'($urandom_range(15, 0));
        end
        if (k != K_CS && k != K_CR) i.busy = 1'($urandom_range(1, 0));
        if (k != K_WLD) i.wtld_done = ($urandom_range(5, 0) == 0);
        if (k != K_WB)  i.wb_done   = ($urandom_range(5, 0) == 0);
        return i;
    endfunction

    function automatic int pick(int f, int lo, int hi);
        return (f >= 0) ? f : int'($urandom_range(hi, lo));
    endfunction

    task automatic push(input int k, input int grp, input bit err, input in_t i);
        ent_t e;
        e.o = mk_out(k, grp, err);
        e.i = i;
        tl.push_back(e);
    endtask

    // kill: 0 none, 1 abort, 2 reset; applied at the first entry of phase
    // kill_seg (0 WLD .. 5 REL) of group kill_g, or at a random entry.
    task automatic build_job(input int n, input int tmo_g, input int kill,
                             input int kill_g, input int kill_seg, input bit kill_any);
        int   kidx;
        int   end_grp;
        bit   end_err;
        int   wd, bd, bl, wbd;
        in_t  i;
        kidx    = -1;
        end_grp = 0;
        end_err = 1'b0;
        tl.delete();
        i = noisy_in(K_IDLE);
        i.start = 1'b1;
        i.num   = 4'(n);
        push(K_IDLE, cur_grp, cur_err, i);
        if (n == 0) begin
            push(K_DONE, 0, 1'b0, noisy_in(K_DONE));
        end else begin
            for (int g = 0; g < n; g++) begin
                wd  = pick(fwd, 0, 4);
                bd  = pick(fbd, 0, 5);
                bl  = pick(fbl, 1, 6);
                wbd = pick(fwbd, 0, 4);
                if (kill != 0 && kidx < 0 && g == kill_g && kill_seg == 0) kidx = tl.size();
                for (int k = 0; k <= wd; k++) begin
                    i = noisy_in(K_WLD);
                    i.wtld_done = (k == wd);
                    push(K_WLD, g, 1'b0, i);
                end
                if (kill != 0 && kidx < 0 && g == kill_g && kill_seg == 1) kidx = tl.size();
                if (g == tmo_g) begin
                    for (int k = 0; k <= TIMEOUT; k++) begin
                        i = noisy_in(K_CS);
                        push(K_CS, g, 1'b0, i);
                    end
                    end_grp = g;
                    end_err = 1'b1;
                    break;
                end
                for (int k = 0; k <= bd; k++) begin
                    i = noisy_in(K_CS);
                    i.busy = (k == bd);
                    push(K_CS, g, 1'b0, i);
                end
                if (kill != 0 && kidx < 0 && g == kill_g && kill_seg == 2) kidx = tl.size();
                for (int k = 0; k < bl; k++) begin
                    i = noisy_in(K_CR);
                    i.busy = (k < bl - 1);
                    push(K_CR, g, 1'b0, i);
                end
                if (kill != 0 && kidx < 0 && g == kill_g && kill_seg == 3) kidx = tl.size();
                for (int k = 0; k < DRAIN_CYC; k++) push(K_DR, g, 1'b0, noisy_in(K_DR));
                if (kill != 0 && kidx < 0 && g == kill_g && kill_seg == 4) kidx = tl.size();
                for (int k = 0; k <= wbd; k++) begin
                    i = noisy_in(K_WB);
                    i.wb_done = (k == wbd);
                    push(K_WB, g, 1'b0, i);
                end
                if (kill != 0 && kidx < 0 && g == kill_g && kill_seg == 5) kidx = tl.size();
                push(K_REL, g, 1'b0, noisy_in(K_REL));
                if (g == n - 1) begin
                    push(K_DONE, g, 1'b0, noisy_in(K_DONE));
                    end_grp = g;
                end
            end
        end
        if (kill != 0 && kill_any) kidx = int'($urandom_range(tl.size() - 1, 0));
        if (kidx >= 0) begin
            if (kill == 1) begin
                tl[kidx].i.abort = 1'b1;
                end_grp = int'(tl[kidx].o.grp);
                end_err = tl[kidx].o.err;
            end else begin
                tl[kidx].i.rstn = 1'b0;
                end_grp = 0;
                end_err = 1'b0;
            end
            while (tl.size() > kidx + 1) void'(tl.pop_back());
        end
        for (int k = 0; k < 3; k++) begin
            i = quiet_in();
            i.wtld_done = 1'($urandom_range(1, 0));
            i.wb_done   = 1'($urandom_range(1, 0));
            i.busy      = 1'($urandom_range(1, 0));
            push(K_IDLE, end_grp, end_err, i);
        end
        cur_grp = end_grp;
        cur_err = end_err;
    endtask

    function automatic out_t obs_vec();
        out_t o;
        o.wtld = WtLdReq_o;
        o.cv   = ConvValid_o;
        o.wb   = WbReq_o;
        o.busy = Busy_o;
        o.done = Done_o;
        o.err  = Err_o;
        o.grp  = GrpIdx_o;
        o.base = WtBase_o;
        return o;
    endfunction

    task automatic apply(input in_t i);
        rstn       = i.rstn;
        Start_i    = i.start;
        NumGrp_i   = i.num;
        Abort_i    = i.abort;
        WtLdDone_i = i.wtld_done;
        ConvBusy_i = i.busy;
        WbDone_i   = i.wb_done;
    endtask

    task automatic run_tl();
        int nd;
        int exp_d;
        nd    = 0;
        exp_d = 0;
        foreach (tl[j]) begin
            chk($sformatf("job%0d_cyc%0d", job, j), 32'(obs_vec()), 32'(tl[j].o));
            if (Done_o === 1'b1) nd++;
            if (tl[j].o.done) exp_d++;
            apply(tl[j].i);
            @(posedge clk);
            #1;
        end
        chk($sformatf("job%0d_done_cnt", job), nd, exp_d);
        job++;
    endtask

    task automatic clr_fixed();
        fwd  = -1;
        fbd  = -1;
        fbl  = -1;
        fwbd = -1;
    endtask

    initial begin
        apply(quiet_in());
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'(obs_vec()), 32'd0);

        // single group, fixed handshake delays
        fwd = 5; fbd = 3; fbl = 20; fwbd = 2;
        build_job(1, -1, 0, 0, 0, 1'b0); run_tl();
        clr_fixed();
        // three groups
        build_job(3, -1, 0, 0, 0, 1'b0); run_tl();
        // conv start timeout, then a start that clears the error
        build_job(1, 0, 0, 0, 0, 1'b0); run_tl();
        build_job(2, -1, 0, 0, 0, 1'b0); run_tl();
        // zero groups
        build_job(0, -1, 0, 0, 0, 1'b0); run_tl();
        // abort in CRUN of group 1 of 3
        build_job(3, -1, 1, 1, 2, 1'b0); run_tl();
        // reset during writeback
        build_job(3, -1, 2, 0, 4, 1'b0); run_tl();
        // largest group count
        build_job(15, -1, 0, 0, 0, 1'b0); run_tl();

        for (int r = 0; r < 25; r++) begin
            int n, tg, kl;
            n  = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(5, 0));
            tg = (n > 0 && $urandom_range(7, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            kl = ($urandom_range(4, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
            build_job(n, tg, kl, 0, 0, 1'b1);
            run_tl();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
